// File: rtl/otter_tmr_pkg.sv
// Shared definitions for the OTTER IOBUS timer: register offsets, CTRL/STATUS bit positions and FSM states.
package otter_tmr_pkg;

  // Byte offsets inside the 32-byte register window; bits [4:2] select the register.
  localparam logic [4:0] OFF_CTRL    = 5'h00;
  localparam logic [4:0] OFF_TC      = 5'h04;
  localparam logic [4:0] OFF_COUNT   = 5'h08;
  localparam logic [4:0] OFF_STATUS  = 5'h0C;
  localparam logic [4:0] OFF_CAPTURE = 5'h10;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_IE        = 1;
  localparam int CTRL_ONESHOT   = 2;
  localparam int CTRL_PS_LSB    = 8;
  localparam int CTRL_PS_MSB    = 15;
  localparam int STATUS_TC_FLAG = 0;
  localparam int STATUS_RUNNING = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tmr_state_e;

endpackage

// File: rtl/otter_tmr_prescaler.sv
// Prescale counter: counts 0..prescale while enabled and emits a one-cycle tick when it reaches prescale.
module otter_tmr_prescaler (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] prescale,
  output logic       tick
);

  logic [7:0] cnt;

  assign tick = enable & (cnt == prescale);

  always_ff @(posedge clk) begin
    if (rst || clear || !enable) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/otter_io_timer.sv
// Memory-mapped IOBUS timer with prescaler, terminal count, one-shot mode and level interrupt.
// Optional count-capture input is enabled by defining OTTER_TMR_CAPTURE_EN.
module otter_io_timer
  import otter_tmr_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1120_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        INTR
`ifdef OTTER_TMR_CAPTURE_EN
  ,
  input  logic        CAPT
`endif
);

  tmr_state_e  state, state_nxt;
  logic        ie, ie_nxt;
  logic        oneshot, oneshot_nxt;
  logic [7:0]  prescale, prescale_nxt;
  logic [31:0] tc, tc_nxt;
  logic [31:0] count, count_nxt;
  logic        tc_flag, tc_flag_nxt;
  logic        run_entry;
  logic        tick;
  logic        terminal;
  logic        hit, wr_hit;
  logic [2:0]  sel;
  logic [31:0] rd_data;
  logic [31:0] capture;
  logic        unused_addr_bits;

  assign hit              = (IOBUS_ADDR[31:5] == BASE_ADDR[31:5]);
  assign sel              = IOBUS_ADDR[4:2];
  assign wr_hit           = IOBUS_WR & hit;
  assign terminal         = tick & (count >= tc);
  assign unused_addr_bits = ^IOBUS_ADDR[1:0];

  otter_tmr_prescaler u_prescaler (
    .clk      (CLK),
    .rst      (RST),
    .clear    (run_entry),
    .enable   (state == RUN),
    .prescale (prescale),
    .tick     (tick)
  );

  // Next-state and register-update logic; a tick always uses the pre-write TC and ONESHOT.
  always_comb begin
    state_nxt    = state;
    ie_nxt       = ie;
    oneshot_nxt  = oneshot;
    prescale_nxt = prescale;
    tc_nxt       = tc;
    count_nxt    = count;
    tc_flag_nxt  = tc_flag;
    run_entry    = 1'b0;

    if (wr_hit && sel == OFF_CTRL[4:2]) begin
      ie_nxt       = IOBUS_OUT[CTRL_IE];
      oneshot_nxt  = IOBUS_OUT[CTRL_ONESHOT];
      prescale_nxt = IOBUS_OUT[CTRL_PS_MSB:CTRL_PS_LSB];
      if (IOBUS_OUT[CTRL_EN] && state != RUN) begin
        state_nxt = RUN;
        run_entry = 1'b1;
      end else if (!IOBUS_OUT[CTRL_EN] && state == RUN) begin
        state_nxt = IDLE;
      end
    end
    if (wr_hit && sel == OFF_TC[4:2]) begin
      tc_nxt = IOBUS_OUT;
    end
    if (wr_hit && sel == OFF_STATUS[4:2] && IOBUS_OUT[STATUS_TC_FLAG]) begin
      tc_flag_nxt = 1'b0;
    end

    if (terminal) begin
      count_nxt   = '0;
      tc_flag_nxt = 1'b1;
      if (oneshot && state_nxt == RUN) begin
        state_nxt = DONE;
      end
    end else if (tick) begin
      count_nxt = count + 32'd1;
    end
    if (run_entry) begin
      count_nxt = '0;
    end
  end

  always_comb begin
    rd_data = '0;
    case (sel)
      OFF_CTRL[4:2]:    rd_data = {16'b0, prescale, 5'b0, oneshot, ie, (state == RUN)};
      OFF_TC[4:2]:      rd_data = tc;
      OFF_COUNT[4:2]:   rd_data = count;
      OFF_STATUS[4:2]:  rd_data = {30'b0, (state == RUN), tc_flag};
      OFF_CAPTURE[4:2]: rd_data = capture;
      default:          rd_data = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      ie       <= 1'b0;
      oneshot  <= 1'b0;
      prescale <= '0;
      tc       <= '0;
      count    <= '0;
      tc_flag  <= 1'b0;
      IOBUS_IN <= '0;
      INTR     <= 1'b0;
    end else begin
      state    <= state_nxt;
      ie       <= ie_nxt;
      oneshot  <= oneshot_nxt;
      prescale <= prescale_nxt;
      tc       <= tc_nxt;
      count    <= count_nxt;
      tc_flag  <= tc_flag_nxt;
      IOBUS_IN <= hit ? rd_data : 32'd0;
      // Registered from next-state values so INTR rises and falls together with TC_FLAG.
      INTR     <= tc_flag_nxt & ie_nxt;
    end
  end

`ifdef OTTER_TMR_CAPTURE_EN
  logic [1:0] capt_sync;
  logic       capt_prev;

  // Two-flop synchronizer plus edge detector; capture takes COUNT before any same-edge update.
  always_ff @(posedge CLK) begin
    if (RST) begin
      capt_sync <= '0;
      capt_prev <= 1'b0;
      capture   <= '0;
    end else begin
      capt_sync <= {capt_sync[0], CAPT};
      capt_prev <= capt_sync[1];
      if (capt_sync[1] && !capt_prev) begin
        capture <= count;
      end
    end
  end
`else
  assign capture = '0;
`endif

endmodule

// File: tb/tb_otter_io_timer.sv
// Directed bench for otter_io_timer: a register-level timer model checked every cycle plus literal expectations.
module tb_otter_io_timer;

  localparam logic [31:0] BASE = 32'h1120_0000;
  localparam logic [31:0] A_CTRL    = BASE + 32'h00;
  localparam logic [31:0] A_TC      = BASE + 32'h04;
  localparam logic [31:0] A_COUNT   = BASE + 32'h08;
  localparam logic [31:0] A_STATUS  = BASE + 32'h0C;
  localparam logic [31:0] A_CAPTURE = BASE + 32'h10;

  logic        clk;
  logic        rst;
  logic [31:0] iobus_addr;
  logic [31:0] iobus_out;
  logic        iobus_wr;
  logic [31:0] iobus_in;
  logic        intr;
`ifdef OTTER_TMR_CAPTURE_EN
  logic        capt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  otter_io_timer #(.BASE_ADDR(BASE)) dut (
    .CLK        (clk),
    .RST        (rst),
    .IOBUS_ADDR (iobus_addr),
    .IOBUS_OUT  (iobus_out),
    .IOBUS_WR   (iobus_wr),
    .IOBUS_IN   (iobus_in),
    .INTR       (intr)
`ifdef OTTER_TMR_CAPTURE_EN
    ,
    .CAPT       (capt)
`endif
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timer model: registers as plain variables; IDLE and DONE look the same from the bus.
  logic        m_valid = 1'b0;
  logic        m_running, m_ie, m_os, m_flag, m_intr;
  logic [7:0]  m_ps, m_phase;
  logic [31:0] m_tc, m_count, m_capture, m_iobus_in;
  logic [2:0]  m_hist;
  logic        m_hit, m_tick, m_term, m_was_running, m_rise;
  logic [2:0]  m_sel;
  logic [31:0] m_old_count;

  function automatic logic [31:0] m_read(input logic [2:0] s);
    case (s)
      3'd0:    return {16'b0, m_ps, 5'b0, m_os, m_ie, m_running};
      3'd1:    return m_tc;
      3'd2:    return m_count;
      3'd3:    return {30'b0, m_running, m_flag};
      3'd4:    return m_capture;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_running = 1'b0; m_ie = 1'b0; m_os = 1'b0; m_flag = 1'b0; m_intr = 1'b0;
      m_ps = '0; m_phase = '0; m_tc = '0; m_count = '0; m_capture = '0;
      m_iobus_in = '0; m_hist = '0;
    end else begin
      m_hit = (iobus_addr[31:5] == BASE[31:5]);
      m_sel = iobus_addr[4:2];
      m_iobus_in = m_hit ? m_read(m_sel) : 32'd0;
      m_was_running = m_running;
      m_old_count = m_count;
      m_tick = m_running && (m_phase == m_ps);
      m_term = m_tick && (m_count >= m_tc);
      if (m_running) m_phase = m_tick ? 8'd0 : m_phase + 8'd1;
      if (m_term) begin
        m_count = 32'd0;
        m_flag = 1'b1;
        if (m_os) m_running = 1'b0;
      end else if (m_tick) begin
        m_count = m_count + 32'd1;
      end
      if (iobus_wr && m_hit) begin
        case (m_sel)
          3'd0: begin
            m_ie = iobus_out[1];
            m_os = iobus_out[2];
            m_ps = iobus_out[15:8];
            if (iobus_out[0] && !m_was_running) begin
              m_running = 1'b1; m_count = 32'd0; m_phase = 8'd0;
            end else if (!iobus_out[0] && m_was_running) begin
              m_running = 1'b0;
            end
          end
          3'd1: m_tc = iobus_out;
          3'd3: if (iobus_out[0] && !m_term) m_flag = 1'b0;
          default: ;
        endcase
      end
      m_intr = m_flag && m_ie;
`ifdef OTTER_TMR_CAPTURE_EN
      m_rise = m_hist[1] && !m_hist[2];
      if (m_rise) m_capture = m_old_count;
      m_hist = {m_hist[1:0], capt};
`endif
    end
  end

  // Scoreboard
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_iobus_in", iobus_in, m_iobus_in);
      check("model_intr", {31'b0, intr}, {31'b0, m_intr});
    end
  end

  // Driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    iobus_addr = a;
    iobus_out  = d;
    iobus_wr   = 1'b1;
    @(posedge clk);
    #1;
    iobus_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    iobus_addr = a;
    @(posedge clk);
    #1;
    d = iobus_in;
  endtask

  logic [31:0] rd;

  initial begin
    rst = 1'b1; iobus_addr = '0; iobus_out = '0; iobus_wr = 1'b0;
`ifdef OTTER_TMR_CAPTURE_EN
    capt = 1'b0;
`endif
    wait_cycles(3);
    rst = 1'b0;

    bus_read(A_CTRL, rd);   check("reset_ctrl", rd, 32'h0);
    bus_read(A_STATUS, rd); check("reset_status", rd, 32'h0);
    bus_read(A_COUNT, rd);  check("reset_count", rd, 32'h0);
    check("reset_intr", {31'b0, intr}, 32'h0);

    // TC=3, EN+IE, PRESCALE=0: COUNT 0,1,2,3,0
    bus_write(A_TC, 32'd3);
    bus_write(A_CTRL, 32'h0000_0003);
    for (int k = 1; k <= 5; k++) begin
      bus_read(A_COUNT, rd);
      check("s1_count_seq", rd, (k == 5) ? 32'd0 : 32'(k - 1));
      if (k == 3) check("s1_intr_low", {31'b0, intr}, 32'h0);
    end
    check("s1_intr_high", {31'b0, intr}, 32'h1);
    bus_write(A_CTRL, 32'h0000_0002);
    bus_read(A_STATUS, rd); check("s1_status_stopped", rd, 32'h1);
    check("s1_intr_held", {31'b0, intr}, 32'h1);
    bus_write(A_STATUS, 32'h1);
    check("s1_intr_cleared", {31'b0, intr}, 32'h0);
    bus_read(A_STATUS, rd); check("s1_status_cleared", rd, 32'h0);

    // Unmapped offset, out-of-window accesses, read-only COUNT
    bus_read(A_COUNT, rd); check("s4_count_held", rd, 32'd2);
    bus_read(A_CTRL, rd);  check("s4_ctrl", rd, 32'h2);
    bus_write(A_COUNT, 32'h1234);
    bus_read(A_COUNT, rd); check("s4_count_ro", rd, 32'd2);
    bus_write(BASE + 32'h24, 32'h55);
    bus_read(A_TC, rd); check("s4_tc_miss_write", rd, 32'd3);
    bus_read(BASE + 32'h14, rd); check("s4_unmapped", rd, 32'h0);
    bus_read(BASE + 32'h24, rd); check("s4_outside", rd, 32'h0);

    // One-shot, PRESCALE=4, TC=1: ticks every 5 cycles, DONE after 2 ticks
    bus_write(A_TC, 32'd1);
    bus_write(A_CTRL, 32'h0000_0407);
    for (int k = 1; k <= 11; k++) begin
      bus_read(A_COUNT, rd);
      check("s2_count_seq", rd, (k >= 6 && k <= 10) ? 32'd1 : 32'd0);
    end
    bus_read(A_CTRL, rd);   check("s2_ctrl_en_cleared", rd, 32'h0000_0406);
    bus_read(A_STATUS, rd); check("s2_status_done", rd, 32'h1);
    bus_read(A_COUNT, rd);  check("s2_count_done", rd, 32'h0);
    check("s2_intr", {31'b0, intr}, 32'h1);
    bus_write(A_STATUS, 32'h1);

    // TC=0: every cycle is terminal, so a W1C always collides with a set
    bus_write(A_TC, 32'd0);
    bus_write(A_CTRL, 32'h0000_0001);
    bus_write(A_STATUS, 32'h1);
    bus_read(A_STATUS, rd); check("s3_set_wins", rd, 32'h3);
    bus_write(A_CTRL, 32'h0);
    bus_read(A_STATUS, rd); check("s3_status_idle", rd, 32'h1);
    bus_read(A_COUNT, rd);  check("s3_count", rd, 32'h0);

    // Reset mid-RUN with COUNT=7
    bus_write(A_TC, 32'd100);
    bus_write(A_CTRL, 32'h0000_0003);
    iobus_addr = A_COUNT;
    wait_cycles(8);
    check("s5_count_pre_reset", iobus_in, 32'd7);
    check("s5_intr_pre_reset", {31'b0, intr}, 32'h1);
    rst = 1'b1;
    wait_cycles(1);
    check("s5_iobus_in_reset", iobus_in, 32'h0);
    check("s5_intr_reset", {31'b0, intr}, 32'h0);
    rst = 1'b0;
    bus_read(A_COUNT, rd);  check("s5_count_reset", rd, 32'h0);
    bus_read(A_STATUS, rd); check("s5_status_reset", rd, 32'h0);
    bus_read(A_CTRL, rd);   check("s5_ctrl_reset", rd, 32'h0);

`ifdef OTTER_TMR_CAPTURE_EN
    // Stop at COUNT=5, pulse CAPT, read CAPTURE
    bus_write(A_TC, 32'd100);
    bus_write(A_CTRL, 32'h0000_0001);
    wait_cycles(4);
    bus_write(A_CTRL, 32'h0);
    capt = 1'b1;
    wait_cycles(1);
    capt = 1'b0;
    wait_cycles(4);
    bus_read(A_CAPTURE, rd); check("cap_value", rd, 32'd5);
`else
    bus_read(A_CAPTURE, rd); check("cap_absent", rd, 32'h0);
`endif

    wait_cycles(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/otter_io_timer.md
OTTER_IO_TIMER -- requirements
Module: otter_io_timer

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h1120_0000, meaning the IOBUS base address of its 32-byte register window; bits [4:0] are ignored.
REQ-002 The block SHALL have ports:
- CLK  input  1  sole clock.
- RST  input  1  synchronous, active-high reset.
- IOBUS_ADDR  input  32  bus address driven by the MCU.
- IOBUS_OUT  input  32  MCU write data.
- IOBUS_WR  input  1  write strobe, one cycle per store.
- IOBUS_IN  output  32  read data returned to the MCU.
- INTR  output  1  interrupt request to the MCU.
REQ-003 One clock only; reset is synchronous and active-high; the port names are CLK and RST.

Function
REQ-004 The block SHALL decode a hit when IOBUS_ADDR[31:5] == BASE_ADDR[31:5]; the register is selected by IOBUS_ADDR[4:2].
REQ-005 The register map SHALL be:
- 0x00 CTRL: [0] EN, [1] IE, [2] ONESHOT, [15:8] PRESCALE; all other bits read 0.
- 0x04 TC: terminal count.
- 0x08 COUNT: read-only.
- 0x0C STATUS: [0] TC_FLAG (write-1-to-clear), [1] RUNNING (read-only).
- 0x10 CAPTURE, per REQ-019.
REQ-006 A write SHALL take effect on the CLK edge where IOBUS_WR=1 and the address hits; writes that miss, and writes to read-only fields, are ignored.
REQ-007 IOBUS_IN SHALL be registered: one cycle after the address is presented, it holds the selected register value, or 0 on a miss or an unmapped offset (the bus is OR-combined).
REQ-008 The state machine SHALL have three states:
- IDLE: EN=0.
- RUN.
- DONE: one-shot expired.
RUNNING=1 only in RUN.
REQ-009 State transitions SHALL be:
- IDLE->RUN when EN is written 1.
- RUN->IDLE when EN is written 0.
- RUN->DONE on a terminal event with ONESHOT=1; EN is cleared in the same cycle.
- DONE->RUN when EN is written 1.
REQ-010 Entry to RUN SHALL zero COUNT and the prescale counter.
REQ-011 In RUN, an 8-bit prescale counter SHALL count 0..PRESCALE; a tick occurs on the cycle it equals PRESCALE, after which it returns to 0. PRESCALE=0 gives a tick every cycle.
REQ-012 On a tick, COUNT >= TC SHALL be a terminal event: COUNT becomes 0 and TC_FLAG is set. Otherwise COUNT increments by 1, wrapping modulo 2^32.
REQ-013 TC=0 SHALL make every tick a terminal event.
REQ-014 A TC write during RUN SHALL take effect at the next tick, with no restart.
REQ-015 INTR SHALL equal TC_FLAG & IE, registered and held high until TC_FLAG is cleared (level handshake).
REQ-016 When a W1C of TC_FLAG coincides with a terminal event, the set SHALL win and TC_FLAG remains 1.
REQ-017 A CTRL write with EN=1 while already in RUN SHALL update IE, ONESHOT and PRESCALE without restarting the count.

Reset
REQ-018 On RST=1 at a CLK edge, the block SHALL:
- clear all registers;
- zero the prescale counter, capture synchronizer and CAPTURE;
- enter IDLE;
- drive IOBUS_IN=0 and INTR=0 from the next cycle.
RST overrides any coincident write or tick.

Configuration
REQ-019 With macro OTTER_TMR_CAPTURE_EN defined, the block SHALL add:
- input port CAPT (1 bit, asynchronous), synchronized by two flops;
- a rising edge on the synchronized CAPT that copies COUNT into CAPTURE (offset 0x10).
A rising edge coincident with a COUNT update SHALL capture the pre-update value.
Without the macro, there is no CAPT port, and offset 0x10 reads 0.

Structure
REQ-020 Package otter_tmr_pkg SHALL hold:
- the register offsets;
- the CTRL/STATUS bit positions;
- the state enum (IDLE, RUN, DONE).
REQ-021 The prescale counter and tick generation SHALL be one sub-module, otter_tmr_prescaler (inputs: clear, enable, 8-bit PRESCALE; output: tick).

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Write TC=3, then CTRL=0x0003 (EN, IE, PRESCALE=0) -> COUNT goes 0,1,2,3,0; TC_FLAG and INTR rise in the cycle after COUNT 3->0; INTR stays high until 0x1 is written to STATUS, then falls the next cycle.
- CTRL=0x0407 (EN, IE, ONESHOT, PRESCALE=4), TC=1 -> a tick every 5 cycles; after 2 ticks, state is DONE, EN=0, RUNNING=0, COUNT=0.
- A W1C to STATUS in the same cycle as a terminal event -> TC_FLAG stays 1.
- Read offset 0x14, and read an address outside the window -> IOBUS_IN=0 one cycle later; a write to COUNT has no effect.
- RST asserted mid-RUN with COUNT=7 -> next cycle COUNT=0, state IDLE, INTR=0, IOBUS_IN=0.
- With OTTER_TMR_CAPTURE_EN, CAPT pulsed high while COUNT=5 -> CAPTURE holds the COUNT value present 2 cycles after the edge; reading 0x10 returns it.
